// File: rtl/kyber_mont_exit.sv
// kyber_mont_exit
// ----------------------------------------------------------------------------
// Purpose:
//   Streaming converter that takes Kyber coefficients out of the Montgomery
//   domain (R = 2^16, q = 3329): out = in * R^-1 mod q = in * 169 mod q.
//   Three-stage unsigned Montgomery reduction behind valid/ready handshakes,
//   with a 256-coefficient output framing counter and a sticky range error.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   input coefficient valid
//   in_ready   out  1   block can accept input this cycle
//   in_data    in   12  Montgomery-domain coefficient (legal 0..3328)
//   out_valid  out  1   output coefficient valid
//   out_ready  in   1   downstream accepts output
//   out_data   out  12  standard-domain coefficient, always 0..3328
//   out_last   out  1   high with out_valid on coefficient index N-1
//   range_err  out  1   sticky: an accepted in_data was >= Q
// ----------------------------------------------------------------------------
module kyber_mont_exit #(
    parameter int Q        = 3329,
    parameter int QNEG_INV = 3327,
    parameter int N        = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data,
    output logic        out_last,
    output logic        range_err
);

    localparam logic [11:0] LP_Q     = 12'(Q);
    localparam logic [15:0] LP_QINV  = 16'(QNEG_INV);
    localparam logic [27:0] LP_Q28   = 28'(Q);
    localparam logic [7:0]  LP_LAST  = 8'(N - 1);

    // Stage registers
    logic        r_s1_valid;
    logic [11:0] r_s1_x;
    logic [15:0] r_s1_m;
    logic        r_s2_valid;
    logic [11:0] r_s2_t;
    logic        r_s3_valid;
    logic [11:0] r_s3_data;
    logic [7:0]  r_idx;
    logic        r_range_err;

    // Combinational datapath
    logic        w_en;
    logic        w_in_hs;
    logic        w_out_hs;
    logic [15:0] w_m;
    logic [27:0] w_p;
    logic [11:0] w_t;
    logic [11:0] w_red;
    logic        w_unused_plow;

    // Whole-pipeline stall: everything advances only when the output slot
    // is empty or being drained this cycle.
    assign w_en     = ~r_s3_valid | out_ready;
    assign w_in_hs  = in_valid & w_en;
    assign w_out_hs = r_s3_valid & out_ready;

    // m = x * (-q^-1) mod 2^16; the 16-bit result width performs the modulo.
    assign w_m = {4'b0000, in_data} * LP_QINV;

    // p = x + m*q is a multiple of 2^16, so its low half is always zero
    // and only p[27:16] carries information.
    assign w_p           = {16'b0, r_s1_x} + ({12'b0, r_s1_m} * LP_Q28);
    assign w_t           = w_p[27:16];
    assign w_unused_plow = ^w_p[15:0];

    // t never exceeds q for any 12-bit input, so one subtract is enough.
    assign w_red = (r_s2_t >= LP_Q) ? (r_s2_t - LP_Q) : r_s2_t;

    // Pipeline stages: valid bits track bubbles, data moves with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_m     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_t     <= '0;
            r_s3_valid <= 1'b0;
            r_s3_data  <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_x     <= in_data;
            r_s1_m     <= w_m;
            r_s2_valid <= r_s1_valid;
            r_s2_t     <= w_t;
            r_s3_valid <= r_s2_valid;
            r_s3_data  <= w_red;
        end
    end

    // Output framing counter: counts completed output handshakes and wraps
    // naturally at 256 because it is 8 bits wide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_out_hs) begin
            r_idx <= r_idx + 8'd1;
        end
    end

    // Sticky range error; the offending coefficient still flows through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_range_err <= 1'b0;
        end else if (w_in_hs && (in_data >= LP_Q)) begin
            r_range_err <= 1'b1;
        end
    end

    assign in_ready  = w_en;
    assign out_valid = r_s3_valid;
    assign out_data  = r_s3_data;
    assign out_last  = r_s3_valid & (r_idx == LP_LAST);
    assign range_err = r_range_err;

endmodule

// File: tb/tb_kyber_mont_exit.sv
// tb_kyber_mont_exit
// ----------------------------------------------------------------------------
// Self-checking bench for kyber_mont_exit. Expected outputs come from plain
// modular arithmetic (x * 169 mod 3329) kept in an in-order queue; framing is
// derived from a count of outputs seen since the last reset.
// ----------------------------------------------------------------------------
module tb_kyber_mont_exit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_last;
    logic        range_err;

    int compared   = 0;
    int mismatched = 0;
    int outCount   = 0;
    int lastSeen   = 0;
    int expQ[$];
    int srcQ[$];

    kyber_mont_exit #(.Q(3329), .QNEG_INV(3327), .N(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    // Reference: leaving the Montgomery domain multiplies by R^-1 = 169.
    function automatic int model(input int x);
        return (x * 169) % 3329;
    endfunction

    // Synchronous-looking reset pulse; leaves us 1 time unit after a posedge.
    task automatic applyReset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        outCount  = 0;
        lastSeen  = 0;
        expQ.delete();
    endtask

    // Streams srcQ through the DUT with random output stalls, scoreboarding
    // every output, its framing flag and stability while stalled.
    task automatic applyStimulus(input int stallPct, input int timeout, output int cycles);
        int  sent;
        int  got;
        int  nIn;
        bit  holdValid;
        logic [11:0] holdData;
        logic holdLast;
        int  exp;
        bit  expLast;
        sent = 0; got = 0; cycles = 0; holdValid = 0;
        holdData = '0; holdLast = 1'b0;
        nIn = srcQ.size();
        while ((sent < nIn || got < nIn) && cycles < timeout) begin
            if (sent < nIn) begin
                in_valid = 1'b1;
                in_data  = 12'(srcQ[sent]);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 99) >= stallPct);
            @(negedge clk);
            if (holdValid) begin
                compared++;
                if (out_valid !== 1'b1 || out_data !== holdData || out_last !== holdLast) begin
                    mismatched++;
                    $display("[TB] FAIL stall_hold: got valid=%b data=%0d last=%b, need valid=1 data=%0d last=%b",
                             out_valid, out_data, out_last, holdData, holdLast);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL spurious_out: got data=%0d, need no output", out_data);
                end else begin
                    exp = expQ.pop_front();
                    if (out_data !== 12'(exp)) begin
                        mismatched++;
                        $display("[TB] FAIL out_data[%0d]: got %0d, need %0d", outCount, out_data, exp);
                    end
                end
                expLast = ((outCount % 256) == 255);
                compared++;
                if (out_last !== expLast) begin
                    mismatched++;
                    $display("[TB] FAIL out_last[%0d]: got %b, need %b", outCount, out_last, expLast);
                end
                if (out_last === 1'b1) lastSeen++;
                outCount++;
                got++;
            end
            holdValid = (out_valid === 1'b1) && !out_ready;
            holdData  = out_data;
            holdLast  = out_last;
            if (in_valid && in_ready === 1'b1) begin
                expQ.push_back(model(srcQ[sent]));
                sent++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        if (cycles >= timeout) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL stream_timeout: got sent=%0d recv=%0d, need %0d each", sent, got, nIn);
        end
    endtask

    task automatic test_reset();
        applyReset();
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'd0 ||
            out_last !== 1'b0 || range_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got rdy=%b vld=%b data=%0d last=%b err=%b, need 1 0 0 0 0",
                     in_ready, out_valid, out_data, out_last, range_err);
        end
        @(posedge clk);
        #1;
    endtask

    // One coefficient presented in cycle 0 must show up in cycle 3.
    task automatic test_latency();
        applyReset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 12'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL latency_early: got out_valid=%b, need 0", out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b1 || out_data !== 12'(model(1))) begin
            mismatched++;
            $display("[TB] FAIL latency_out: got vld=%b data=%0d, need vld=1 data=%0d",
                     out_valid, out_data, model(1));
        end
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bubble: got out_valid=%b, need 0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    // Known vectors back-to-back: 4 inputs + 3 cycles of latency = 7 cycles.
    task automatic test_known();
        int cycles;
        applyReset();
        srcQ = '{2285, 1, 0, 3328};
        applyStimulus(0, 100, cycles);
        compared++;
        if (cycles != 7) begin
            mismatched++;
            $display("[TB] FAIL known_throughput: got %0d cycles, need 7", cycles);
        end
    endtask

    task automatic test_sweep();
        int cycles;
        applyReset();
        srcQ.delete();
        for (int i = 0; i < 3329; i++) srcQ.push_back(i);
        applyStimulus(30, 20000, cycles);
        compared++;
        if (outCount != 3329 || expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL sweep_count: got %0d outputs (%0d pending), need 3329 (0)",
                     outCount, expQ.size());
        end
    endtask

    task automatic test_framing();
        int cycles;
        applyReset();
        srcQ.delete();
        for (int i = 0; i < 512; i++) srcQ.push_back(int'($urandom_range(0, 3328)));
        applyStimulus(0, 2000, cycles);
        compared++;
        if (lastSeen != 2) begin
            mismatched++;
            $display("[TB] FAIL framing_lasts: got %0d out_last pulses, need 2", lastSeen);
        end
    endtask

    task automatic test_illegal();
        applyReset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 12'd4095;
        @(negedge clk);
        compared++;
        if (range_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL err_early: got %b, need 0", range_err);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (range_err !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL err_set: got %b, need 1", range_err);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b1 || out_data !== 12'(model(4095))) begin
            mismatched++;
            $display("[TB] FAIL illegal_out: got vld=%b data=%0d, need vld=1 data=%0d",
                     out_valid, out_data, model(4095));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 12'd7;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (range_err !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL err_sticky: got %b, need 1", range_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int cycles;
        applyReset();
        srcQ.delete();
        for (int i = 0; i < 10; i++) srcQ.push_back(int'($urandom_range(0, 3328)));
        applyStimulus(0, 100, cycles);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 1) ? 12'd4000 : 12'(100 + i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b1 || range_err !== 1'b1 || in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL pre_reset: got vld=%b err=%b rdy=%b, need 1 1 0",
                     out_valid, range_err, in_ready);
        end
        #1;
        rst = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || range_err !== 1'b0 || out_last !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got vld=%b rdy=%b err=%b last=%b, need 0 1 0 0",
                     out_valid, in_ready, range_err, out_last);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        outCount = 0;
        lastSeen = 0;
        expQ.delete();
        srcQ.delete();
        for (int i = 0; i < 256; i++) srcQ.push_back(int'($urandom_range(0, 3328)));
        applyStimulus(20, 2000, cycles);
        compared++;
        if (lastSeen != 1) begin
            mismatched++;
            $display("[TB] FAIL reset_reframe: got %0d out_last pulses, need 1", lastSeen);
        end
    endtask

    task automatic test_back_to_back();
        int expVals[4];
        applyReset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'b1;
            in_data    = 12'(500 + 37 * i);
            expVals[i] = model(500 + 37 * i);
            @(posedge clk);
            #1;
        end
        in_data    = 12'd2222;
        expVals[3] = model(2222);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            compared++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 12'(expVals[0])) begin
                mismatched++;
                $display("[TB] FAIL stall_full: got rdy=%b vld=%b data=%0d, need 0 1 %0d",
                         in_ready, out_valid, out_data, expVals[0]);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 12'(expVals[0])) begin
            mismatched++;
            $display("[TB] FAIL dual_handshake: got rdy=%b vld=%b data=%0d, need 1 1 %0d",
                     in_ready, out_valid, out_data, expVals[0]);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b1 || out_data !== 12'(expVals[i])) begin
                mismatched++;
                $display("[TB] FAIL drain[%0d]: got vld=%b data=%0d, need 1 %0d",
                         i, out_valid, out_data, expVals[i]);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL drain_empty: got out_valid=%b, need 0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    // Test sequence
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_latency();
        test_known();
        test_sweep();
        test_framing();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
